iiitb_lfsr_mon: RTL and testbench
=================================

IIITB_LFSR_MON -- requirements
Module: iiitb_lfsr_mon

Interface
REQ-001 The block SHALL sit directly downstream of the 4-bit LFSR and consume its serial output bit stream.
REQ-002 Parameter: WORD_W, 8, deserializer word width; legal range 4..15.
REQ-003 Parameter: MAX_PERIOD, 31, search-bit limit before timeout; legal range 5..31.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  arm or restart the period measurement.
REQ-007 Port: en  input  1  din is valid and is sampled this edge.
REQ-008 Port: din  input  1  serial bit from the LFSR q output.
REQ-009 Port: word  output  WORD_W  last assembled word; first-received bit is the MSB.
REQ-010 Port: word_valid  output  1  one-cycle pulse when word updates.
REQ-011 Port: word_ones  output  4  count of 1 bits in word; updates together with word.
REQ-012 Port: period  output  5  measured sequence period in sampled bits.
REQ-013 Port: period_valid  output  1  period measurement complete; held.
REQ-014 Port: stuck_err  output  1  stuck stream detected; held.
REQ-015 Port: timeout_err  output  1  no repeat found within MAX_PERIOD bits; held.
REQ-016 Port: busy  output  1  high in FILL and SEARCH.

Function
REQ-017 With en=0, no internal state SHALL change, and word_valid SHALL be 0 on the following cycle.
REQ-018 Deserializer (independent of the FSM): on each en edge, din SHALL shift into the LSB and the bit counter SHALL increment.
REQ-019 On the edge sampling the WORD_W-th bit, word, word_ones and word_valid=1 SHALL update on that same edge (zero added latency), and the bit counter SHALL wrap to 0.
REQ-020 FSM states SHALL be IDLE, FILL, SEARCH, DONE and ERROR.
REQ-021 start=1 in any state SHALL enter FILL and clear the window, fill count, run count, period counter, period, period_valid, stuck_err and timeout_err.
REQ-022 The din bit sampled in the start cycle SHALL be ignored by the FSM; the deserializer SHALL still take it.
REQ-023 FILL: each en bit SHALL shift into the 4-bit window; after 4 bits, ref SHALL be loaded from the window and the FSM SHALL enter SEARCH with pcount=0.
REQ-024 SEARCH: each en bit SHALL shift the window and increment pcount.
REQ-025 In SEARCH, if window==ref after the shift, the FSM SHALL enter DONE with period=pcount (this bit included) and period_valid=1.
REQ-026 In SEARCH, if pcount reaches MAX_PERIOD without a match, the FSM SHALL enter ERROR with timeout_err=1.
REQ-027 If a match and a timeout occur on the same bit, the match SHALL win.
REQ-028 Run counter: tracks consecutive identical en-sampled bits in FILL and SEARCH; 3 bits, saturating.
REQ-029 When the run counter reaches 5, the FSM SHALL enter ERROR with stuck_err=1.
REQ-030 Stuck detection SHALL take priority over both match and timeout on the same bit.
REQ-031 DONE and ERROR SHALL hold all flags until start or rst.
REQ-032 IDLE SHALL ignore din except through the deserializer.

Reset
REQ-033 rst=1 SHALL, at the next edge, set the FSM to IDLE and clear every output and internal register to 0, overriding start and en.
REQ-034 Reset mid-FILL or mid-SEARCH SHALL abort the measurement with no flags set.

Verification
REQ-035 Assert rst mid-SEARCH -> all outputs 0 and busy=0 after one edge.
REQ-036 Drive a maximal 4-bit LFSR (seed 0001), en=1 each cycle, pulse start -> period_valid=1 after 19 sampled bits with period=15; no error flags.
REQ-037 Send bits 1,0,1,1,0,0,1,0 -> word=8'hB2, word_ones=4, word_valid high for exactly one cycle.
REQ-038 Send an all-zero stream after start -> stuck_err=1 on the 5th bit; period_valid=0.
REQ-039 Repeat REQ-036 with en asserted every other cycle -> period=15, and words identical to the gap-free run.
REQ-040 Send 1,0,0,0, then repeat 1,1,0,0 -> timeout_err=1 after 31 SEARCH bits; stuck_err=0.

Source files
------------

// File: rtl/iiitb_lfsr_mon.sv
// Monitor for the serial output of a 4-bit LFSR.
// Two independent parts share the sampled bit stream:
//   * a deserializer that packs every WORD_W sampled bits into a word
//     (first-received bit ends up as the MSB) and counts its ones;
//   * a measurement FSM that captures the first 4 bits after start as a
//     reference pattern and counts bits until the sliding 4-bit window
//     repeats it, flagging stuck streams and runaway searches.
module iiitb_lfsr_mon #(
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned MAX_PERIOD = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic              din,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic [3:0]        word_ones,
  output logic [4:0]        period,
  output logic              period_valid,
  output logic              stuck_err,
  output logic              timeout_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SEARCH,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);
  localparam logic [4:0] PLIMIT   = 5'(MAX_PERIOD);
  localparam logic [2:0] RUN_STUCK = 3'd5;
  localparam logic [2:0] RUN_MAX   = 3'd7;

  // ------------------------------------------------------------------
  // Deserializer
  // ------------------------------------------------------------------
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [3:0]        bcnt_q;
  logic [WORD_W-1:0] word_q;
  logic [3:0]        ones_q, ones_d;
  logic              wv_q;

  // Next shift-register contents and the popcount of that candidate word.
  always_comb begin
    sr_d   = {sr_q[WORD_W-2:0], din};
    ones_d = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      ones_d = ones_d + 4'(sr_d[i]);
    end
  end

  // Shift on every enabled bit; publish the word on the edge that takes its last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      bcnt_q <= '0;
      word_q <= '0;
      ones_q <= '0;
      wv_q   <= 1'b0;
    end else begin
      wv_q <= 1'b0;
      if (en) begin
        sr_q <= sr_d;
        if (bcnt_q == LAST_BIT) begin
          bcnt_q <= '0;
          word_q <= sr_d;
          ones_q <= ones_d;
          wv_q   <= 1'b1;
        end else begin
          bcnt_q <= bcnt_q + 4'd1;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Period measurement FSM
  // ------------------------------------------------------------------
  state_t     state_q;
  logic [3:0] win_q, win_d;
  logic [3:0] ref_q;
  logic [2:0] fill_q;
  logic [2:0] run_q, run_d;
  logic       last_q;
  logic [4:0] pcnt_q, pcnt_d;
  logic [4:0] period_q;
  logic       pv_q;
  logic       stuck_q;
  logic       tout_q;
  logic       busy_q;
  logic       hit_stuck;
  logic       hit_match;
  logic       hit_tout;

  // Candidate window/run/pcount values for the bit being sampled, plus
  // the three terminating conditions evaluated against them.
  always_comb begin
    win_d  = {win_q[2:0], din};
    pcnt_d = pcnt_q + 5'd1;
    if (run_q != '0 && din == last_q) begin
      run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 3'd1;
    end else begin
      run_d = 3'd1;
    end
    hit_stuck = (run_d == RUN_STUCK);
    hit_match = (win_d == ref_q);
    hit_tout  = (pcnt_d == PLIMIT);
  end

  // Measurement FSM: start re-arms from any state; stuck beats match beats timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      ref_q    <= '0;
      fill_q   <= '0;
      run_q    <= '0;
      last_q   <= 1'b0;
      pcnt_q   <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      stuck_q  <= 1'b0;
      tout_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (start) begin
      state_q  <= S_FILL;
      win_q    <= '0;
      ref_q    <= '0;
      fill_q   <= '0;
      run_q    <= '0;
      last_q   <= 1'b0;
      pcnt_q   <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      stuck_q  <= 1'b0;
      tout_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      case (state_q)
        S_FILL: begin
          if (en) begin
            win_q  <= win_d;
            last_q <= din;
            run_q  <= run_d;
            fill_q <= fill_q + 3'd1;
            if (hit_stuck) begin
              state_q <= S_ERROR;
              stuck_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (fill_q == 3'd3) begin
              ref_q   <= win_d;
              pcnt_q  <= '0;
              state_q <= S_SEARCH;
            end
          end
        end
        S_SEARCH: begin
          if (en) begin
            win_q  <= win_d;
            last_q <= din;
            run_q  <= run_d;
            pcnt_q <= pcnt_d;
            if (hit_stuck) begin
              state_q <= S_ERROR;
              stuck_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (hit_match) begin
              state_q  <= S_DONE;
              period_q <= pcnt_d;
              pv_q     <= 1'b1;
              busy_q   <= 1'b0;
            end else if (hit_tout) begin
              state_q <= S_ERROR;
              tout_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          // IDLE, DONE and ERROR hold everything until start or rst.
        end
      endcase
    end
  end

  assign word         = word_q;
  assign word_valid   = wv_q;
  assign word_ones    = ones_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign stuck_err    = stuck_q;
  assign timeout_err  = tout_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_iiitb_lfsr_mon.sv
// Bench for iiitb_lfsr_mon: directed scenarios plus a random phase, all
// checked every cycle against a bit-history reference model.
module tb_iiitb_lfsr_mon;

  localparam int W    = 8;
  localparam int MAXP = 31;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         en = 1'b0;
  logic         din = 1'b0;
  logic [W-1:0] word;
  logic         word_valid;
  logic [3:0]   word_ones;
  logic [4:0]   period;
  logic         period_valid;
  logic         stuck_err;
  logic         timeout_err;
  logic         busy;

  int total = 0;
  int bad   = 0;

  iiitb_lfsr_mon #(.WORD_W(W), .MAX_PERIOD(MAXP)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .din(din),
    .word(word), .word_valid(word_valid), .word_ones(word_ones),
    .period(period), .period_valid(period_valid),
    .stuck_err(stuck_err), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: histories of sampled bits, interpreted by the rules.
  bit           db[$];      // bits of the word being assembled
  bit           mb[$];      // measurement bits since start
  int           m_mode;     // 0 idle, 1 measuring, 2 finished
  logic [W-1:0] m_word;
  logic [3:0]   m_ones;
  bit           m_wv;
  logic [4:0]   m_period;
  bit           m_pv, m_stuck, m_to;

  logic [W-1:0] ref_words[$];
  logic [W-1:0] obs_words[$];
  logic [3:0]   lfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit s, input bit e, input bit d);
    int n;
    bit all_same, rep;
    logic [W-1:0] v;
    int ones;
    if (r) begin
      db.delete(); mb.delete();
      m_mode = 0; m_word = '0; m_ones = '0; m_wv = 0;
      m_period = '0; m_pv = 0; m_stuck = 0; m_to = 0;
      return;
    end
    m_wv = 0;
    if (e) begin
      db.push_back(d);
      if (db.size() == W) begin
        v = '0; ones = 0;
        foreach (db[i]) begin
          v = {v[W-2:0], db[i]};
          ones += int'(db[i]);
        end
        m_word = v; m_ones = 4'(ones); m_wv = 1;
        db.delete();
      end
    end
    if (s) begin
      m_mode = 1; mb.delete();
      m_period = '0; m_pv = 0; m_stuck = 0; m_to = 0;
    end else if (m_mode == 1 && e) begin
      mb.push_back(d);
      n = mb.size();
      all_same = (n >= 5);
      if (n >= 5) for (int k = n - 5; k < n; k++) if (mb[k] != d) all_same = 0;
      rep = (n > 4);
      if (n > 4) for (int k = 0; k < 4; k++) if (mb[n - 4 + k] != mb[k]) rep = 0;
      if (all_same) begin
        m_stuck = 1; m_mode = 2;
      end else if (rep) begin
        m_period = 5'(n - 4); m_pv = 1; m_mode = 2;
      end else if (n - 4 == MAXP) begin
        m_to = 1; m_mode = 2;
      end
    end
  endtask

  task automatic check_all();
    chk("word", word, m_word);
    chk("word_ones", word_ones, m_ones);
    chk("word_valid", word_valid, m_wv);
    chk("period", period, m_period);
    chk("period_valid", period_valid, m_pv);
    chk("stuck_err", stuck_err, m_stuck);
    chk("timeout_err", timeout_err, m_to);
    chk("busy", busy, m_mode == 1);
  endtask

  task automatic step(input bit r, input bit s, input bit e, input bit d);
    rst = r; start = s; en = e; din = d;
    @(posedge clk);
    #1;
    model(r, s, e, d);
    if (word_valid === 1'b1) obs_words.push_back(word);
    check_all();
  endtask

  function automatic bit lfsr_next();
    bit o;
    o = lfsr[3];
    lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    return o;
  endfunction

  initial begin
    logic [7:0] pat;
    bit b;

    // Reset state
    step(1, 1, 1, 1);
    chk("reset_word", word, 0);
    chk("reset_busy", busy, 0);

    // Deserializer: 1,0,1,1,0,0,1,0 -> 8'hB2
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) begin
      step(0, 0, 1, pat[i]);
      if (i == 1) chk("b2_early_valid", word_valid, 0);
    end
    chk("b2_word", word, 8'hB2);
    chk("b2_ones", word_ones, 4);
    chk("b2_valid", word_valid, 1);
    step(0, 0, 0, 1);
    chk("b2_valid_drop", word_valid, 0);
    chk("b2_word_hold", word, 8'hB2);

    // Gap-free LFSR period measurement
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    lfsr = 4'b0001;
    ref_words.delete();
    for (int i = 1; i <= 24; i++) begin
      step(0, 0, 1, lfsr_next());
      if (m_wv) ref_words.push_back(m_word);
      if (i == 18) chk("lfsr_pv_before19", period_valid, 0);
      if (i == 19) begin
        chk("lfsr_pv_at19", period_valid, 1);
        chk("lfsr_period", period, 15);
      end
    end
    chk("lfsr_stuck", stuck_err, 0);
    chk("lfsr_timeout", timeout_err, 0);

    // Same stream with en every other cycle
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    lfsr = 4'b0001;
    obs_words.delete();
    for (int i = 1; i <= 24; i++) begin
      step(0, 0, 1, lfsr_next());
      step(0, 0, 0, 1'($urandom));
    end
    chk("gap_period", period, 15);
    chk("gap_pv", period_valid, 1);
    chk("gap_nwords", obs_words.size(), ref_words.size());
    for (int i = 0; i < obs_words.size() && i < ref_words.size(); i++)
      chk("gap_word", obs_words[i], ref_words[i]);

    // All-zero stream -> stuck on 5th bit
    step(1, 0, 0, 0);
    step(0, 1, 1, 1);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 1, 0);
      if (i == 4) chk("stuck_before5", stuck_err, 0);
    end
    chk("stuck_at5", stuck_err, 1);
    chk("stuck_pv", period_valid, 0);
    step(0, 0, 1, 1);
    chk("stuck_hold", stuck_err, 1);

    // 1,0,0,0 then 1,1,0,0 repeating -> timeout after 31 search bits
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    pat = 8'b1000_1100;
    for (int i = 0; i < 4; i++) step(0, 0, 1, pat[7 - i]);
    for (int i = 1; i <= 31; i++) begin
      step(0, 0, 1, pat[3 - ((i - 1) % 4)]);
      if (i == 30) chk("to_before31", timeout_err, 0);
    end
    chk("to_at31", timeout_err, 1);
    chk("to_stuck", stuck_err, 0);
    chk("to_pv", period_valid, 0);

    // Reset in the middle of SEARCH
    step(0, 1, 0, 0);
    lfsr = 4'b0001;
    for (int i = 0; i < 6; i++) step(0, 0, 1, lfsr_next());
    chk("mid_busy", busy, 1);
    step(1, 1, 1, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pv", period_valid, 0);
    chk("rst_period", period, 0);
    chk("rst_word", word, 0);
    chk("rst_ones", word_ones, 0);

    // Random traffic with occasional restarts and resets
    for (int i = 0; i < 600; i++) begin
      b = ($urandom_range(0, 99) < 2);
      step(b, ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
           (($urandom_range(0, 3) == 0) ? lfsr_next() : 1'($urandom)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
